mbp_nway_chooser: RTL

- Next-generation meta/choice predictor for the CVA6 frontend.
- Arbitrates among NUM_COMP component predictors (e.g. local, global, loop) per fetch slot, instead of a fixed two-way chooser.
- Holds one saturating confidence counter per component, per slot, per row. Selects the component with the highest counter; updates through a registered read-modify-write pipeline.
- Adds a sequential flush walker with busy indication and a prediction write-bypass.

---
 rtl/mbp_pkg.sv | 32 +++
 rtl/mbp_argmax.sv | 27 ++
 rtl/mbp_nway_chooser.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mbp_pkg.sv
// Shared types and helpers for the N-way choice predictor.
package mbp_pkg;

  localparam int unsigned MaxCtrBits  = 4;
  localparam int unsigned MaxComp     = 4;
  localparam int unsigned MaxRowBits  = 16;
  localparam int unsigned MaxSlotBits = 4;

  typedef logic [MaxCtrBits-1:0] choice_ctr_t;

  // Fields are sized for the largest legal configuration; users narrow them.
  typedef struct packed {
    logic [MaxRowBits-1:0]  row;
    logic [MaxSlotBits-1:0] slot;
    logic [MaxComp-1:0]     correct;
    logic [MaxComp-1:0]     comp_valid;
  } mbp_upd_t;

  typedef enum logic [0:0] {
    StIdle,
    StFlush
  } mbp_state_e;

  function automatic choice_ctr_t ctr_mid(input int unsigned bits);
    return choice_ctr_t'(1 << (bits - 1));
  endfunction

  function automatic choice_ctr_t ctr_max(input int unsigned bits);
    return choice_ctr_t'((1 << bits) - 1);
  endfunction

endpackage

// File: rtl/mbp_argmax.sv
// NUM_COMP-way maximum of confidence counters; ties resolve to the lowest index.
module mbp_argmax
  import mbp_pkg::*;
#(
  parameter int unsigned NUM_COMP = 3,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned SEL_BITS = $clog2(NUM_COMP)
) (
  input  logic [NUM_COMP*CTR_BITS-1:0] ctrs,
  output logic [SEL_BITS-1:0]          sel
);

  logic [CTR_BITS-1:0] best;

  always_comb begin
    sel  = '0;
    best = ctrs[CTR_BITS-1:0];
    // Strict compare keeps the earlier winner on a tie.
    for (int unsigned c = 1; c < NUM_COMP; c++) begin
      if (ctrs[c*CTR_BITS +: CTR_BITS] > best) begin
        best = ctrs[c*CTR_BITS +: CTR_BITS];
        sel  = SEL_BITS'(c);
      end
    end
  end

endmodule

// File: rtl/mbp_nway_chooser.sv
// Meta predictor choosing among NUM_COMP component predictors per fetch slot,
// with a registered read-modify-write update path and a row-walking flush.
module mbp_nway_chooser
  import mbp_pkg::*;
#(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter bit          RVC             = 1'b1,
  parameter int unsigned NUM_COMP        = 3,
  parameter int unsigned CTR_BITS        = 2,
  parameter int unsigned NR_ENTRIES      = 1024
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          flush_i,
  input  logic                                          debug_mode_i,
  input  logic [VLEN-1:0]                               vpc_i,
  output logic [INSTR_PER_FETCH*$clog2(NUM_COMP)-1:0]   select_o,
  output logic                                          select_valid_o,
  output logic                                          flush_busy_o,
  input  logic                                          upd_valid_i,
  input  logic [VLEN-1:0]                               upd_pc_i,
  input  logic                                          upd_unaligned_i,
  input  logic                                          upd_taken_i,
  input  logic [NUM_COMP-1:0]                           upd_comp_valid_i,
  input  logic [NUM_COMP-1:0]                           upd_comp_taken_i
);

  localparam int unsigned IPF       = INSTR_PER_FETCH;
  localparam int unsigned OFFSET    = RVC ? 1 : 2;
  localparam int unsigned SLOT_BITS = $clog2(IPF);
  localparam int unsigned SLOT_W    = (SLOT_BITS > 0) ? SLOT_BITS : 1;
  localparam int unsigned NR_ROWS   = NR_ENTRIES / IPF;
  localparam int unsigned ROW_BITS  = $clog2(NR_ROWS);
  localparam int unsigned SEL_BITS  = $clog2(NUM_COMP);

  typedef logic [CTR_BITS-1:0] ctr_t;

  localparam ctr_t CTR_MID = CTR_BITS'(ctr_mid(CTR_BITS));
  localparam ctr_t CTR_MAX = CTR_BITS'(ctr_max(CTR_BITS));

  function automatic logic [ROW_BITS-1:0] row_of(input logic [VLEN-1:0] pc);
    return ROW_BITS'(pc >> (SLOT_BITS + OFFSET));
  endfunction

  function automatic logic [SLOT_W-1:0] slot_of(input logic [VLEN-1:0] pc);
    return (SLOT_BITS == 0) ? '0 : SLOT_W'(pc >> OFFSET);
  endfunction

  ctr_t                ctr_q [NR_ROWS][IPF][NUM_COMP];
  mbp_state_e          state_q, state_d;
  logic [ROW_BITS-1:0] walk_q, walk_d;
  logic                u1_valid_q, u1_valid_d;
  mbp_upd_t            u1_q, u1_d;
  logic [IPF*SEL_BITS-1:0] select_q, select_d;
  logic                select_valid_q, select_valid_d;

  // Flush walker
  always_comb begin
    state_d = state_q;
    walk_d  = walk_q;
    unique case (state_q)
      StIdle: begin
        if (flush_i) begin
          state_d = StFlush;
          walk_d  = '0;
        end
      end
      StFlush: begin
        if (flush_i) begin
          walk_d = '0;
        end else if (walk_q == ROW_BITS'(NR_ROWS - 1)) begin
          state_d = StIdle;
        end else begin
          walk_d = walk_q + ROW_BITS'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic flush_wr;
  assign flush_wr     = (state_q == StFlush);
  assign flush_busy_o = flush_wr;

  // U1: capture the resolved branch
  logic [ROW_BITS-1:0] upd_row;
  logic [SLOT_W-1:0]   upd_slot;
  logic [NUM_COMP-1:0] upd_correct;

  always_comb begin
    upd_row     = row_of(upd_pc_i);
    upd_slot    = upd_unaligned_i ? '0 : slot_of(upd_pc_i);
    upd_correct = upd_comp_valid_i & ~(upd_comp_taken_i ^ {NUM_COMP{upd_taken_i}});

    u1_d            = '0;
    u1_d.row        = MaxRowBits'(upd_row);
    u1_d.slot       = MaxSlotBits'(upd_slot);
    u1_d.correct    = MaxComp'(upd_correct);
    u1_d.comp_valid = MaxComp'(upd_comp_valid_i);
    // A flush starting this edge discards the update as well.
    u1_valid_d      = upd_valid_i && !debug_mode_i && (state_q == StIdle) && !flush_i;
  end

  // U2: read-modify-write of the captured entry
  logic [ROW_BITS-1:0] u2_row;
  logic [SLOT_W-1:0]   u2_slot;
  logic [NUM_COMP-1:0] u2_correct, u2_wrong;
  logic                u2_we;
  ctr_t                u2_new [NUM_COMP];

  always_comb begin
    u2_row     = ROW_BITS'(u1_q.row);
    u2_slot    = SLOT_W'(u1_q.slot);
    u2_correct = NUM_COMP'(u1_q.correct);
    u2_wrong   = NUM_COMP'(u1_q.comp_valid) & ~u2_correct;
    u2_we      = u1_valid_q && (|u2_correct) && (|u2_wrong) && (state_q == StIdle) && !flush_i;
    for (int unsigned c = 0; c < NUM_COMP; c++) begin
      u2_new[c] = ctr_q[u2_row][u2_slot][c];
      if (u2_correct[c]) begin
        if (u2_new[c] != CTR_MAX) u2_new[c] = u2_new[c] + ctr_t'(1);
      end else if (u2_wrong[c]) begin
        if (u2_new[c] != '0) u2_new[c] = u2_new[c] - ctr_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned r = 0; r < NR_ROWS; r++) begin
        for (int unsigned s = 0; s < IPF; s++) begin
          for (int unsigned c = 0; c < NUM_COMP; c++) begin
            ctr_q[r][s][c] <= CTR_MID;
          end
        end
      end
    end else if (flush_wr) begin
      for (int unsigned s = 0; s < IPF; s++) begin
        for (int unsigned c = 0; c < NUM_COMP; c++) begin
          ctr_q[walk_q][s][c] <= CTR_MID;
        end
      end
    end else if (u2_we) begin
      for (int unsigned c = 0; c < NUM_COMP; c++) begin
        ctr_q[u2_row][u2_slot][c] <= u2_new[c];
      end
    end
  end

  // Prediction with bypass of the write committing on the same edge
  logic [ROW_BITS-1:0]          pred_row;
  logic                         pred_byp;
  logic [NUM_COMP*CTR_BITS-1:0] pred_ctrs [IPF];
  logic [SEL_BITS-1:0]          pred_sel  [IPF];

  always_comb begin
    pred_row = row_of(vpc_i);
    pred_byp = u2_we && (u2_row == pred_row);
    for (int unsigned s = 0; s < IPF; s++) begin
      pred_ctrs[s] = '0;
      for (int unsigned c = 0; c < NUM_COMP; c++) begin
        if (pred_byp && (u2_slot == SLOT_W'(s))) begin
          pred_ctrs[s][c*CTR_BITS +: CTR_BITS] = u2_new[c];
        end else begin
          pred_ctrs[s][c*CTR_BITS +: CTR_BITS] = ctr_q[pred_row][s][c];
        end
      end
    end
  end

  for (genvar s = 0; s < IPF; s++) begin : g_slot
    mbp_argmax #(
      .NUM_COMP (NUM_COMP),
      .CTR_BITS (CTR_BITS),
      .SEL_BITS (SEL_BITS)
    ) u_argmax (
      .ctrs (pred_ctrs[s]),
      .sel  (pred_sel[s])
    );
  end

  always_comb begin
    select_d = '0;
    for (int unsigned s = 0; s < IPF; s++) begin
      select_d[s*SEL_BITS +: SEL_BITS] = pred_sel[s];
    end
    // Low during the walk and for one cycle after it ends.
    select_valid_d = (state_q == StIdle) && (state_d == StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      walk_q         <= '0;
      u1_valid_q     <= 1'b0;
      u1_q           <= '0;
      select_q       <= '0;
      select_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      walk_q         <= walk_d;
      u1_valid_q     <= u1_valid_d;
      u1_q           <= u1_d;
      select_q       <= select_d;
      select_valid_q <= select_valid_d;
    end
  end

  assign select_o       = select_q;
  assign select_valid_o = select_valid_q;

endmodule
